// File: rtl/sw_debounce_pkg.sv
// ----------------------------------------------------------------------------
// sw_debounce_pkg
// Shared types and constants for the N-channel switch debouncer.
//   state_e            : per-channel debounce FSM state (STABLE / CANDIDATE)
//   MIN_SYNC_STAGES    : smallest synchroniser depth that is accepted
//   MAX_SYNC_STAGES    : largest synchroniser depth that is accepted
//   MIN_STABLE_CYCLES  : smallest stable-time window that is accepted
// ----------------------------------------------------------------------------
package sw_debounce_pkg;

  // STABLE: sw_out agrees with the synchronised input.
  // CANDIDATE: the synchronised input differs and the difference is being timed.
  typedef enum logic {
    STABLE    = 1'b0,
    CANDIDATE = 1'b1
  } state_e;

  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MAX_SYNC_STAGES   = 4;
  localparam int MIN_STABLE_CYCLES = 2;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_ch.sv
// ----------------------------------------------------------------------------
// sw_debounce_ch
// One switch channel: a synchroniser chain followed by a stable-time debounce
// FSM with a candidate counter and registered rise/fall strobes.
// Ports:
//   clk     : system clock
//   resetn  : asynchronous, active-low reset
//   sw_in   : raw asynchronous switch pin
//   sw_out  : debounced level
//   sw_rise : one-cycle pulse in the first cycle sw_out is 1 after being 0
//   sw_fall : one-cycle pulse in the first cycle sw_out is 0 after being 1
//   sw_busy : channel is timing a candidate change
// ----------------------------------------------------------------------------
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 100000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state;
  logic [CNT_W-1:0]       cnt;

  // Plain shift chain into the clock domain; nothing combinational may sit
  // between these flops or metastability settling time is lost. The chain
  // resets to the channel's idle level so release does not look like an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM. A change is accepted only once s has disagreed with sw_out
  // on STABLE_CYCLES consecutive samples: the sample that enters CANDIDATE
  // counts as the first, and the sample seen with cnt == STABLE_CYCLES-1 is
  // the last. Any agreeing sample in between throws the candidate away.
  // Strobes default low so each fires for exactly the cycle sw_out updates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= STABLE;
      cnt     <= '0;
      sw_out  <= RESET_LEVEL;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      case (state)
        STABLE: begin
          if (s != sw_out) begin
            state <= CANDIDATE;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CANDIDATE: begin
          if (s == sw_out) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            sw_out  <= s;
            sw_rise <= s;
            sw_fall <= ~s;
            state   <= STABLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign sw_busy = (state == CANDIDATE);

endmodule : sw_debounce_ch

// File: rtl/sw_debounce_nch.sv
// ----------------------------------------------------------------------------
// sw_debounce_nch
// N-channel switch conditioner placed between the raw switch pins and the
// switch event/IRQ controller. Each channel is synchronised and debounced
// independently and reports its clean level plus rise/fall strobes.
// Ports:
//   clk     : system clock (aclk at the parent)
//   resetn  : asynchronous, active-low reset (aresetn at the parent)
//   sw_in   : [N_CH] raw asynchronous switch pins
//   sw_out  : [N_CH] debounced levels
//   sw_rise : [N_CH] one-cycle pulse when sw_out goes 0->1
//   sw_fall : [N_CH] one-cycle pulse when sw_out goes 1->0
//   sw_busy : [N_CH] channel is timing a candidate change
// ----------------------------------------------------------------------------
module sw_debounce_nch
  import sw_debounce_pkg::*;
#(
  parameter int              N_CH          = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter int              STABLE_CYCLES = 100000,
  parameter logic [N_CH-1:0] RESET_LEVEL   = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_out,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic [N_CH-1:0] sw_busy
);

  // Reject configurations the channel logic cannot honour: a single-flop
  // synchroniser is unsafe, and a one-cycle window leaves no room for the
  // candidate state.
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("sw_debounce_nch: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end
  if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable
    $error("sw_debounce_nch: STABLE_CYCLES=%0d below %0d",
           STABLE_CYCLES, MIN_STABLE_CYCLES);
  end

  // One self-contained channel per switch; each gets its own slice of the
  // reset level so mixed idle polarities work.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL[i])
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .sw_in   (sw_in[i]),
      .sw_out  (sw_out[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i]),
      .sw_busy (sw_busy[i])
    );
  end

endmodule : sw_debounce_nch

// File: doc/sw_debounce_nch.md
Name: sw_debounce_nch

Overview:
- Parameterised N-channel switch/button conditioner: a synchroniser chain per channel, followed by a per-channel stable-time debounce FSM.
- Produces clean levels plus single-cycle rise/fall strobes.
- Sits directly upstream of the switch event/IRQ controller, between the raw SW pins and its SW input, clocked by the AXI-Lite aclk.
- Replaces fixed x4 filtering with a generic, width- and timing-configurable stage.

Parameters:
- N_CH, 4, number of independent switch channels.
- SYNC_STAGES, 2, flops in the input synchroniser; legal range 2..4.
- STABLE_CYCLES, 100000, consecutive cycles a synchronised value must differ from sw_out before sw_out follows; 1 ms at 100 MHz; minimum 2.
- RESET_LEVEL, N_CH'b0, per-channel value loaded into the synchroniser and sw_out at reset.

Ports:
- clk  input  1  system clock; aclk at the parent.
- resetn  input  1  asynchronous, active-low reset; aresetn at the parent.
- sw_in  input  N_CH  raw asynchronous switch pins.
- sw_out  output  N_CH  debounced level.
- sw_rise  output  N_CH  one-cycle pulse, asserted in the cycle sw_out goes 0->1.
- sw_fall  output  N_CH  one-cycle pulse, asserted in the cycle sw_out goes 1->0.
- sw_busy  output  N_CH  channel is in the CANDIDATE state (candidate change being timed).

Behaviour:
- Reset (async assert, sync release via normal flop behaviour):
  - Synchroniser flops = RESET_LEVEL; sw_out = RESET_LEVEL.
  - sw_rise, sw_fall, sw_busy = 0; counters = 0; FSM = STABLE.
- Synchroniser: s = last flop of a SYNC_STAGES chain. No logic between chain flops.
- Per-channel FSM:
  - STABLE: if s != sw_out -> CANDIDATE, cnt <= 1. Otherwise stay, cnt = 0.
  - CANDIDATE, s == sw_out: -> STABLE, cnt <= 0. The glitch is rejected and no strobe fires.
  - CANDIDATE, s != sw_out and cnt == STABLE_CYCLES-1: sw_out <= s; the matching rise/fall strobe is registered high for exactly one cycle; -> STABLE, cnt <= 0.
  - CANDIDATE, otherwise: cnt <= cnt+1.
- sw_out therefore changes only after s has differed from it for exactly STABLE_CYCLES consecutive samples.
- Latency from a clean input step to sw_out toggling = SYNC_STAGES + STABLE_CYCLES clock edges.
- Counter width = $clog2(STABLE_CYCLES). The counter never exceeds STABLE_CYCLES-1; there is no wrap.
- sw_busy = (state == CANDIDATE). It is registered state, not a combinational decode of s.
- Strobes are registered and coincide with the first cycle of the new sw_out value. sw_rise and sw_fall are never both high on one channel.
- Channels are fully independent: simultaneous transitions on several channels each strobe on their own schedule.
- Input toggling every cycle: the FSM alternates STABLE/CANDIDATE and sw_out never changes.
- Reset mid-count: everything returns to reset values immediately, with no strobe on reset or release. If sw_in differs from RESET_LEVEL after release, a normal full-latency transition follows.
- Elaboration check: $error if STABLE_CYCLES < 2 or SYNC_STAGES < 2.

Decomposition:
- Package sw_debounce_pkg: enum typedef for the FSM state {STABLE, CANDIDATE}; localparam min-value constants for the elaboration checks.
- One sub-module, sw_debounce_ch: a single channel containing the sync chain, FSM, counter and strobes.
- The top generates N_CH instances of sw_debounce_ch and slices RESET_LEVEL per channel.

Test Plan:
(Bench parameters: N_CH=4, SYNC_STAGES=2, STABLE_CYCLES=8, RESET_LEVEL=4'b0000.)
- Reset, sw_in held at 4'b0000 for 50 cycles -> sw_out=0, no strobes, sw_busy=0 throughout.
- sw_in[0] steps 0->1 before edge e0 -> sw_out[0]=1 after exactly 10 edges; sw_rise[0] high for that one cycle only; sw_busy[0] high for the 8 preceding cycles.
- sw_in[1] pulses high for 7 cycles, then low -> sw_out[1] stays 0, no strobe, sw_busy[1] drops when s returns low.
- sw_in[3:2] set to 2'b11, with ch3 stepping 3 cycles after ch2 -> sw_rise[2] and sw_rise[3] fire 3 cycles apart; ch0/ch1 are unaffected.
- With sw_out[0]=1, sw_in[0] goes 0 and resetn is pulsed low at count 5 -> sw_out=0000 immediately, no strobe. After release with sw_in=0001, sw_rise[0] fires 10 edges later.
- sw_in[2] toggles every cycle for 100 cycles -> sw_out[2] is constant and no strobe fires.
